qos_retry_arb: RTL

QOS_RETRY_ARB -- requirements
Module: qos_retry_arb

---
 rtl/qos_retry_arb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/qos_retry_arb.sv
`default_nettype none
// ============================================================================
// Module   : qos_retry_arb
// Brief    : QoS retry-slot arbiter. It picks the highest pending class, with
//            a starvation override that forces lower-class service. Within a
//            class, slots are served round-robin. The handshake is
//            offer/clean, and a cleared slot emits a one-cycle clean pulse.
// Revision : 1.0 - initial release
// ============================================================================
module qos_retry_arb #(
  parameter int SLOT_NUM       = 4,
  parameter int QOS_CLASS_TYPE = 4,
  parameter int STARVE_LIMIT   = 15
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [SLOT_NUM*QOS_CLASS_TYPE-1:0]   slot_flag,
  input  logic                                 grant_ready,
  output logic                                 grant_valid,
  output logic [$clog2(SLOT_NUM)-1:0]          grant_slot,
  output logic [$clog2(QOS_CLASS_TYPE)-1:0]    grant_class,
  output logic                                 grant_starve,
  output logic [SLOT_NUM-1:0]                  slot_clean
);

  localparam int SW  = $clog2(SLOT_NUM);
  localparam int SW1 = SW + 1;
  localparam int CW  = $clog2(QOS_CLASS_TYPE);
  localparam int TW  = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OFFER = 2'd1;
  localparam logic [1:0] CLEAN = 2'd2;

  localparam logic [TW-1:0]  STARVE_MAX = TW'(STARVE_LIMIT);
  localparam logic [SW-1:0]  LAST_SLOT  = SW'(SLOT_NUM - 1);
  localparam logic [SW1-1:0] SLOT_WRAP  = SW1'(SLOT_NUM);

  logic [1:0]                state, state_nxt;
  logic [SW-1:0]             rr_ptr;
  logic [TW-1:0]             starve_cnt;
  logic                      lower_seen;   // a class below the granted one was pending when chosen

  logic [CW-1:0]             slot_cls [SLOT_NUM];
  logic [SLOT_NUM-1:0]       slot_req;
  logic [QOS_CLASS_TYPE-1:0] cls_pend;
  logic [CW-1:0]             hi_cls, lo_cls, win_cls;
  logic                      win_starve, win_lower, win_found;
  logic [SW-1:0]             win_slot, rr_idx;
  logic [SW1-1:0]            rr_sum;
  logic                      any_flag, handshake;

  assign any_flag  = |slot_flag;
  assign handshake = (state == OFFER) && grant_ready;

  // Per-slot class decode: highest set flag bit wins, empty vector = no request
  always_comb begin
    slot_req = '0;
    cls_pend = '0;
    for (int s = 0; s < SLOT_NUM; s++) begin
      slot_cls[s] = '0;
      for (int c = 0; c < QOS_CLASS_TYPE; c++) begin
        if (slot_flag[s*QOS_CLASS_TYPE + c]) begin
          slot_cls[s] = CW'(c);
          slot_req[s] = 1'b1;
        end
      end
      if (slot_req[s]) cls_pend[slot_cls[s]] = 1'b1;
    end
  end

  // Winning class (with starvation override) and round-robin slot within it
  always_comb begin
    hi_cls = '0;
    lo_cls = '0;
    for (int c = 0; c < QOS_CLASS_TYPE; c++)
      if (cls_pend[c]) hi_cls = CW'(c);
    for (int c = QOS_CLASS_TYPE - 1; c >= 0; c--)
      if (cls_pend[c]) lo_cls = CW'(c);
    win_starve = (starve_cnt == STARVE_MAX) && (lo_cls < hi_cls);
    win_cls    = win_starve ? lo_cls : hi_cls;
    win_lower  = any_flag && (lo_cls < win_cls);
    win_slot   = '0;
    win_found  = 1'b0;
    rr_sum     = '0;
    rr_idx     = '0;
    for (int k = 0; k < SLOT_NUM; k++) begin
      rr_sum = {1'b0, rr_ptr} + SW1'(k);
      if (rr_sum >= SLOT_WRAP) rr_sum = rr_sum - SLOT_WRAP;
      rr_idx = rr_sum[SW-1:0];
      if (!win_found && slot_req[rr_idx] && (slot_cls[rr_idx] == win_cls)) begin
        win_slot  = rr_idx;
        win_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_flag) state_nxt = OFFER;
      OFFER:   if (grant_ready) state_nxt = CLEAN;
      CLEAN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; clean pulse targets the held grant slot
  always_comb begin
    grant_valid = (state == OFFER);
    slot_clean  = '0;
    if (state == CLEAN) slot_clean[grant_slot] = 1'b1;
  end

  // Capture the selection on IDLE->OFFER; it stays frozen until the next selection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_slot   <= '0;
      grant_class  <= '0;
      grant_starve <= 1'b0;
      lower_seen   <= 1'b0;
    end else if ((state == IDLE) && any_flag) begin
      grant_slot   <= win_slot;
      grant_class  <= win_cls;
      grant_starve <= win_starve;
      lower_seen   <= win_lower;
    end
  end

  // Round-robin pointer and starvation counter advance on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else if (handshake) begin
      rr_ptr <= (grant_slot == LAST_SLOT) ? '0 : grant_slot + 1'b1;
      if (grant_starve || !lower_seen)  starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
